// File: rtl/out_port.sv
// Output port for the 8-bit bus CPU: captures OUT bytes into a small FWFT FIFO,
// delivers them over valid/ready and keeps a display copy of the last delivered byte.
module out_port #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic [WIDTH-1:0]           bus,
  output logic                       full,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           last_out,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] last_out_r;
  logic             overflow_r;

  logic             empty_s;
  logic             full_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic [CW-1:0]    count_nxt_s;

  // A push is allowed at full only when the head leaves on the same edge.
  always_comb begin
    empty_s = (count_r == {CW{1'b0}});
    full_s  = (count_r == FULL_CNT);
    pop_s   = !empty_s && out_ready;
    push_s  = load && (!full_s || pop_s);
    drop_s  = load && full_s && !pop_s;
  end

  // Occupancy next-state: push and pop together leave it unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointer, occupancy, display and sticky-overflow registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_r   <= {AW{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      last_out_r <= {WIDTH{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + AW'(1);
        last_out_r <= mem_r[rd_ptr_r];
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Storage array; contents are unreachable after reset since count is cleared.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_r[wr_ptr_r] <= bus;
    end
  end

  assign full      = full_s;
  assign out_valid = !empty_s;
  assign out_data  = empty_s ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];
  assign count     = count_r;
  assign last_out  = last_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_out_port.sv
// Bench for out_port: queue-based reference model checked every cycle, plus
// directed scenarios with literal expected values.
module tb_out_port;

  localparam int DEPTH = 4;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             load = 1'b0;
  logic [WIDTH-1:0] bus = 8'h00;
  logic             full;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       count;
  logic [WIDTH-1:0] last_out;
  logic             overflow;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  out_port #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .load(load), .bus(bus), .full(full),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .last_out(last_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: a plain queue of pending bytes.
  logic [7:0] m_q[$];
  logic [7:0] m_last = 8'h00;
  bit         m_ovf = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_last = 8'h00;
      m_ovf  = 1'b0;
    end else begin
      bit pop;
      pop = (m_q.size() != 0) && out_ready;
      if (pop) begin
        m_last = m_q[0];
        void'(m_q.pop_front());
      end
      if (load) begin
        if (m_q.size() < DEPTH) m_q.push_back(bus);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Delivered bytes, as seen by the consumer.
  logic [7:0] delivered[$];
  bit         hold_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (check_en) begin
      logic [7:0] exp_data;
      exp_data = (m_q.size() != 0) ? m_q[0] : 8'h00;
      check("count", 32'(count), 32'(m_q.size()));
      check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
      check("full", 32'(full), 32'(m_q.size() == DEPTH));
      check("out_data", 32'(out_data), 32'(exp_data));
      check("last_out", 32'(last_out), 32'(m_last));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("count_max", 32'(count <= 3'd4), 32'd1);
      if (hold_prev) check("out_data_stable", 32'(out_data), 32'(data_prev));
      if (out_valid && out_ready && rst) delivered.push_back(out_data);
      hold_prev = out_valid && !out_ready && rst;
      data_prev = out_data;
    end
  end

  task automatic step(input logic l, input logic [7:0] b, input logic r);
    load = l; bus = b; out_ready = r;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    for (int i = 0; i < cycles; i++) step(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
  endtask

  task automatic check_seq(input string name, input logic [7:0] exp[$]);
    check({name, "_len"}, 32'(delivered.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < delivered.size(); i++)
      check(name, 32'(delivered[i]), 32'(exp[i]));
  endtask

  initial begin
    @(posedge clk); #1;
    // Reset then idle
    rst = 1'b0; step(1'b0, 8'h00, 1'b0);
    check_en = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_data", 32'(out_data), 32'h00);
    check("rst_last", 32'(last_out), 32'h00);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Single pass-through
    step(1'b1, 8'h2A, 1'b1);
    check("pt_valid", 32'(out_valid), 32'd1);
    check("pt_data", 32'(out_data), 32'h2A);
    step(1'b0, 8'h00, 1'b1);
    check("pt_valid_after", 32'(out_valid), 32'd0);
    check("pt_last", 32'(last_out), 32'h2A);

    // Fill and overflow
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_ovf_pre", 32'(overflow), 32'd0);
    step(1'b1, 8'h05, 1'b0);
    check("fill_ovf", 32'(overflow), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    delivered.delete();
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    check_seq("fill_drain", '{8'h01, 8'h02, 8'h03, 8'h04});
    check("fill_empty", 32'(out_valid), 32'd0);
    check("fill_ovf_sticky", 32'(overflow), 32'd1);
    check("fill_last", 32'(last_out), 32'h04);

    // Push at full with simultaneous pop
    do_reset(1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h10 + 8'(i), 1'b0);
    delivered.delete();
    step(1'b1, 8'h14, 1'b1);
    check("pf_count", 32'(count), 32'd4);
    check("pf_ovf", 32'(overflow), 32'd0);
    check("pf_head", 32'(out_data), 32'h11);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    check_seq("pf_drain", '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14});

    // Back-pressure and pointer wrap; loads stall while full, like the controller
    do_reset(1);
    delivered.delete();
    begin
      int sent = 0;
      int cyc = 0;
      bit rdy = 1'b1;
      while ((sent < 10 || out_valid) && cyc < 100) begin
        if (sent < 10 && !full) begin
          step(1'b1, 8'hA0 + 8'(sent), rdy);
          sent++;
        end else begin
          step(1'b0, 8'h00, rdy);
        end
        rdy = !rdy;
        cyc++;
      end
      check("bp_timeout", 32'(cyc < 100), 32'd1);
    end
    check_seq("bp_order", '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4,
                            8'hA5, 8'hA6, 8'hA7, 8'hA8, 8'hA9});
    check("bp_ovf", 32'(overflow), 32'd0);
    check("bp_last", 32'(last_out), 32'hA9);

    // Reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 8'h30 + 8'(i), 1'b0);
    check("mid_count_pre", 32'(count), 32'd3);
    rst = 1'b0;
    step(1'b1, 8'hEE, 1'b1);
    rst = 1'b1;
    check("mid_count", 32'(count), 32'd0);
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_full", 32'(full), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    check("mid_not_stored", 32'(count), 32'd0);
    check("mid_data", 32'(out_data), 32'h00);
    check("mid_last", 32'(last_out), 32'h00);

    step(1'b0, 8'h00, 1'b0);
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
